// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fc_pkg
// Description : Shared types and helpers for the fc_* stream blocks
//               (argmax sink and the fc control FSM family).
// Revision    : 1.0 - initial release
// ============================================================================
package fc_pkg;

  // Two-phase sink: collect M elements, then hold the result word.
  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } sink_state_t;

  // Index width that never collapses to zero bits (M == 1 still needs a port).
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fc_argmax_sink_update.sv
`default_nettype none
// ============================================================================
// Module      : argmax_update
// Description : Combinational compare/select step of the running argmax.
//               The first element of a vector always wins; afterwards a new
//               element wins only if strictly greater (signed), so ties keep
//               the lowest index.
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_update #(
  parameter int T  = 16,
  parameter int IW = 3
) (
  input  logic          first,
  input  logic [T-1:0]  data,
  input  logic [T-1:0]  cur_max,
  input  logic [IW-1:0] cur_idx,
  input  logic [IW-1:0] count,
  output logic [T-1:0]  next_max,
  output logic [IW-1:0] next_idx
);

  logic take;

  // Select the incoming element when it starts a vector or beats the running max.
  always_comb begin
    take     = first || ($signed(data) > $signed(cur_max));
    next_max = take ? data  : cur_max;
    next_idx = take ? count : cur_idx;
  end

endmodule
`default_nettype wire

// File: rtl/fc_argmax_sink.sv
`default_nettype none
// ============================================================================
// Module      : fc_argmax_sink
// Description : Final classifier stage after an fc layer. Consumes one
//               M-element signed vector over valid/ready, tracks the running
//               maximum and presents {index, value} on a second valid/ready
//               port. Handshake outputs decode registered state only.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_argmax_sink
  import fc_pkg::*;
#(
  parameter int M = 8,
  parameter int T = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      input_valid,
  output logic                      input_ready,
  input  logic [T-1:0]              input_data,
  output logic                      output_valid,
  input  logic                      output_ready,
  output logic [clog2_min1(M)-1:0]  output_index,
  output logic [T-1:0]              output_max
);

  localparam int           IW       = clog2_min1(M);
  localparam logic [T-1:0] MOST_NEG = {1'b1, {(T-1){1'b0}}};
  localparam logic [IW-1:0] LAST    = IW'(M - 1);

  sink_state_t   state, state_n;
  logic [IW-1:0] count;
  logic [T-1:0]  max_r;
  logic [IW-1:0] idx_r;
  logic [T-1:0]  upd_max;
  logic [IW-1:0] upd_idx;
  logic          accept;

  // Handshake flags come straight from the state register.
  assign input_ready  = (state == S_COLLECT);
  assign output_valid = (state == S_HOLD);
  assign accept       = input_valid && input_ready;

  // Result word reads zero except while it is being offered.
  assign output_index = output_valid ? idx_r : '0;
  assign output_max   = output_valid ? max_r : '0;

  argmax_update #(
    .T  (T),
    .IW (IW)
  ) u_update (
    .first    (count == '0),
    .data     (input_data),
    .cur_max  (max_r),
    .cur_idx  (idx_r),
    .count    (count),
    .next_max (upd_max),
    .next_idx (upd_idx)
  );

  // Next-state: leave COLLECT on the last element, leave HOLD on the output handshake.
  always_comb begin
    state_n = state;
    case (state)
      S_COLLECT: if (accept && (count == LAST)) state_n = S_HOLD;
      S_HOLD:    if (output_ready)              state_n = S_COLLECT;
      default:   state_n = S_COLLECT;
    endcase
  end

  // State, element counter and running max/index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_COLLECT;
      count <= '0;
      max_r <= MOST_NEG;
      idx_r <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_COLLECT: begin
          if (accept) begin
            max_r <= upd_max;
            idx_r <= upd_idx;
            count <= (count == LAST) ? '0 : count + IW'(1);
          end
        end
        S_HOLD: begin
          if (output_ready) begin
            max_r <= MOST_NEG;
            idx_r <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_argmax_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_argmax_sink
// Description : Self-checking bench for fc_argmax_sink (M=8, T=16) using
//               directed and $urandom vectors against an array-based argmax
//               reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_argmax_sink;

  localparam int M  = 8;
  localparam int T  = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          input_valid;
  logic          input_ready;
  logic [T-1:0]  input_data;
  logic          output_valid;
  logic          output_ready;
  logic [IW-1:0] output_index;
  logic [T-1:0]  output_max;

  int errors = 0;
  int checks = 0;

  typedef int vec_t [M];

  fc_argmax_sink #(.M(M), .T(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_index (output_index),
    .output_max   (output_max)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: first occurrence of the largest value.
  task automatic ref_argmax(input vec_t v, output int idx, output int mx);
    idx = 0;
    mx  = v[0];
    for (int i = 1; i < M; i++)
      if (v[i] > mx) begin
        mx  = v[i];
        idx = i;
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed one vector (optionally with 1010 bubbles), check latency, then stall
  // the result for `stall` cycles before taking it.
  task automatic run_vector(input string tag, input vec_t v, input bit bubbles, input int stall);
    int eidx, emax;
    ref_argmax(v, eidx, emax);
    for (int i = 0; i < M; i++) begin
      if (bubbles) begin
        input_valid = 1'b0;
        input_data  = 16'h5A5A;
        tick();
        check({tag, " bubble_valid"}, int'(output_valid), 0);
      end
      input_valid = 1'b1;
      input_data  = v[i][T-1:0];
      if (i == 0) check({tag, " in_ready"}, int'(input_ready), 1);
      tick();
      if (i == M - 2) check({tag, " early_valid"}, int'(output_valid), 0);
    end
    // Upstream keeps offering junk; it must be ignored during the hold.
    input_valid = 1'b1;
    input_data  = 16'h7FFF;
    check({tag, " out_valid"}, int'(output_valid), 1);
    check({tag, " index"}, int'(output_index), eidx);
    check({tag, " max"}, int'($signed(output_max)), emax);
    for (int s = 0; s < stall; s++) begin
      tick();
      check({tag, " stall_valid"}, int'(output_valid), 1);
      check({tag, " stall_ready"}, int'(input_ready), 0);
      check({tag, " stall_index"}, int'(output_index), eidx);
      check({tag, " stall_max"}, int'($signed(output_max)), emax);
    end
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    input_valid  = 1'b0;
    check({tag, " after_valid"}, int'(output_valid), 0);
    check({tag, " after_ready"}, int'(input_ready), 1);
  endtask

  initial begin
    vec_t v;
    int   exp_idx_q[$];
    int   exp_max_q[$];
    int   cur [M];
    int   ncur, nres, last_cyc, ei, em;

    reset        = 1'b1;
    input_valid  = 1'b0;
    input_data   = '0;
    output_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", int'(output_valid), 0);
    check("rst_ready", int'(input_ready), 1);
    check("rst_index", int'(output_index), 0);
    check("rst_max", int'($signed(output_max)), 0);
    reset = 1'b0;
    tick();

    v = '{3, -5, 7, 7, 2, -1, 0, 1};
    run_vector("s1", v, 1'b0, 0);
    v = '{-100, -3, -50, -3, -128, -7, -9, -4};
    run_vector("s2a", v, 1'b0, 0);
    v = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    run_vector("s2b", v, 1'b0, 0);
    v = '{3, -5, 7, 7, 2, -1, 0, 1};
    run_vector("s3", v, 1'b0, 5);
    run_vector("s4", v, 1'b1, 1);

    // Abort a partial vector with an asynchronous reset pulse mid-cycle.
    for (int i = 0; i < 4; i++) begin
      input_valid = 1'b1;
      input_data  = 16'd9;
      tick();
    end
    input_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("s5 rst_valid", int'(output_valid), 0);
    check("s5 rst_ready", int'(input_ready), 1);
    tick();
    reset = 1'b0;
    tick();
    v = '{0, 0, 0, 0, 0, 0, 0, 5};
    run_vector("s5", v, 1'b0, 0);

    // Random vectors with random bubbles/stalls.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < M; i++) v[i] = int'($signed(16'($urandom)));
      if (r == 1) v[5] = v[2];
      run_vector("rnd", v, bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Back-to-back stream with output_ready held high and a scoreboard.
    output_ready = 1'b1;
    ncur = 0;
    nres = 0;
    last_cyc = -1;
    for (int c = 1; c <= 3 * (M + 1) + 1; c++) begin
      input_valid = 1'b1;
      input_data  = 16'($urandom);
      if (input_ready) begin
        cur[ncur] = int'($signed(input_data));
        ncur++;
        if (ncur == M) begin
          ref_argmax(cur, ei, em);
          exp_idx_q.push_back(ei);
          exp_max_q.push_back(em);
          ncur = 0;
        end
      end
      tick();
      if (output_valid) begin
        if (exp_idx_q.size() == 0) begin
          check("s6 unexpected_result", 1, 0);
        end else begin
          check("s6 index", int'(output_index), exp_idx_q.pop_front());
          check("s6 max", int'($signed(output_max)), exp_max_q.pop_front());
        end
        if (last_cyc >= 0) check("s6 spacing", c - last_cyc, M + 1);
        last_cyc = c;
        nres++;
      end
    end
    input_valid  = 1'b0;
    output_ready = 1'b0;
    check("s6 results", nres, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
